// File: rtl/alu_sequencer.sv
// Sequences one MultiStageALU operation per request: load A, execute into G, read RES back.
// Optional macro ALU_FLAGS_EN: ZERO/NEG track the captured result; otherwise both are tied to 0.
module alu_sequencer #(
    parameter int N = 10
) (
    input  logic         CLKb,
    input  logic         RSTb,
    input  logic         START,
    input  logic [3:0]   FN_IN,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         READY,
    output logic         DONE,
    output logic         ERR,
    output logic [N-1:0] RESULT,
    output logic         ZERO,
    output logic         NEG,
    output logic [N-1:0] OP,
    output logic [3:0]   FN,
    output logic         AIN,
    output logic         GIN,
    output logic         GOUT,
    input  logic [N-1:0] ALU_RES
);

    typedef enum logic [2:0] {IDLE, LOADA, EXEC, READ, FIN} state_t;

    state_t       state_reg, state_next;
    logic [3:0]   fn_reg;
    logic [N-1:0] x_reg;
    logic [N-1:0] y_reg;
    logic         err_reg;
    logic [N-1:0] result_reg;
    logic         fn_legal;

    assign fn_legal = (FN_IN >= 4'd2) && (FN_IN <= 4'd11);

    // The ALU shares this falling edge, so every capture here lines up with its own.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_reg  <= IDLE;
            fn_reg     <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            err_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && START) begin
                fn_reg  <= FN_IN;
                x_reg   <= X;
                y_reg   <= Y;
                err_reg <= !fn_legal;
            end
            if (state_reg == READ) begin
                result_reg <= ALU_RES;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic zero_reg;
    logic neg_reg;

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
        end else if (state_reg == READ) begin
            zero_reg <= (ALU_RES == '0);
            neg_reg  <= ALU_RES[N-1];
        end
    end

    assign ZERO = zero_reg;
    assign NEG  = neg_reg;
`else
    assign ZERO = 1'b0;
    assign NEG  = 1'b0;
`endif

    assign RESULT = result_reg;

    // Outputs depend on state only, so a reset drops every strobe immediately.
    always_comb begin
        state_next = state_reg;
        READY      = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        AIN        = 1'b0;
        GIN        = 1'b0;
        GOUT       = 1'b0;
        OP         = '0;
        FN         = '0;
        case (state_reg)
            IDLE: begin
                READY = 1'b1;
                if (START) begin
                    state_next = fn_legal ? LOADA : FIN;
                end
            end
            LOADA: begin
                OP         = x_reg;
                AIN        = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                OP         = y_reg;
                FN         = fn_reg;
                GIN        = 1'b1;
                state_next = READ;
            end
            READ: begin
                OP         = y_reg;
                FN         = fn_reg;
                GOUT       = 1'b1;
                state_next = FIN;
            end
            FIN: begin
                DONE       = 1'b1;
                ERR        = err_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU stand-in, a request-level reference
// model feeding a queue, and a per-cycle monitor that checks strobes, latency and results.
module tb_alu_sequencer;
    localparam int N = 10;

    logic         CLKb = 1'b1;
    logic         RSTb = 1'b0;
    logic         START = 1'b0;
    logic [3:0]   FN_IN = '0;
    logic [N-1:0] X = '0;
    logic [N-1:0] Y = '0;
    logic         READY, DONE, ERR, ZERO, NEG, AIN, GIN, GOUT;
    logic [N-1:0] RESULT, OP, ALU_RES;
    logic [3:0]   FN;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    alu_sequencer #(.N(N)) dut (
        .CLKb(CLKb), .RSTb(RSTb), .START(START), .FN_IN(FN_IN), .X(X), .Y(Y),
        .READY(READY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT), .ZERO(ZERO), .NEG(NEG),
        .OP(OP), .FN(FN), .AIN(AIN), .GIN(GIN), .GOUT(GOUT), .ALU_RES(ALU_RES)
    );

    always #5 CLKb = ~CLKb;
    always @(negedge CLKb) cyc++;

    // Function table of the ALU stand-in used by this bench.
    function automatic logic [N-1:0] alu_f(input logic [3:0] f, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [N-1:0] r;
        case (f)
            4'd2:  r = a + b;
            4'd3:  r = a - b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = a & b;
            4'd7:  r = ~a;
            4'd8:  r = b - a;
            4'd9:  r = a << b;
            4'd10: r = a >> b;
            4'd11: r = N'($signed(a) >>> b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // ALU stand-in: RES carries junk whenever GOUT is low, so mistimed captures show up.
    logic [N-1:0] alu_a = '0;
    logic [N-1:0] alu_g = '0;
    always @(negedge CLKb) begin
        if (AIN) alu_a <= OP;
        if (GIN) alu_g <= alu_f(FN, alu_a, OP);
    end
    assign ALU_RES = GOUT ? alu_g : (alu_g ^ 10'h2AA);

    typedef struct {
        logic [3:0]   fn;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] res;
        logic         err;
        logic         zero;
        logic         neg;
        int           k;
    } entry_t;

    entry_t q[$];
    logic [N-1:0] last_res = '0;
    logic last_zero = 1'b0;
    logic last_neg = 1'b0;

    function automatic void push(input logic [3:0] f, input logic [N-1:0] x,
                                 input logic [N-1:0] y, input int k);
        entry_t e;
        e.fn = f; e.x = x; e.y = y; e.k = k;
        e.err = !(f >= 4'd2 && f <= 4'd11);
        if (!e.err) begin
            last_res = alu_f(f, x, y);
`ifdef ALU_FLAGS_EN
            last_zero = (last_res == 0);
            last_neg  = last_res[N-1];
`endif
        end
        e.res = last_res; e.zero = last_zero; e.neg = last_neg;
        q.push_back(e);
    endfunction

    // Monitor: expected control outputs follow from the head request's age in cycles.
    always @(posedge CLKb) begin
        logic [2*N+9:0] exp_v, act_v;
        logic e_ready, e_done, e_err, e_ain, e_gin, e_gout;
        logic [N-1:0] e_op;
        logic [3:0] e_fn;
        entry_t h;
        int d;
        if (RSTb) begin
            e_ready = 1'b1; e_done = 0; e_err = 0; e_ain = 0; e_gin = 0; e_gout = 0;
            e_op = '0; e_fn = '0; d = -1;
            if (q.size() > 0 && q[0].k <= cyc) begin
                h = q[0];
                d = cyc - h.k;
                e_ready = 1'b0;
                if (h.err) begin
                    e_done = (d == 0); e_err = (d == 0);
                end else begin
                    case (d)
                        0: begin e_ain = 1; e_op = h.x; end
                        1: begin e_gin = 1; e_op = h.y; e_fn = h.fn; end
                        2: begin e_gout = 1; e_op = h.y; e_fn = h.fn; end
                        3: e_done = 1;
                        default: ;
                    endcase
                end
            end
            exp_v = {e_ready, e_done, e_err, e_ain, e_gin, e_gout, e_op, e_fn, {N{1'b0}}};
            act_v = {READY, DONE, ERR, AIN, GIN, GOUT, OP, FN, {N{1'b0}}};
            checks++;
            if (exp_v !== act_v) begin
                failures++;
                $display("FAIL ctrl cyc=%0d got rdy/done/err/ain/gin/gout=%b%b%b%b%b%b op=%h fn=%h want %b%b%b%b%b%b op=%h fn=%h",
                         cyc, READY, DONE, ERR, AIN, GIN, GOUT, OP, FN,
                         e_ready, e_done, e_err, e_ain, e_gin, e_gout, e_op, e_fn);
            end
            if (e_done) begin
                checks++;
                if ({ERR, RESULT, ZERO, NEG} !== {h.err, h.res, h.zero, h.neg}) begin
                    failures++;
                    $display("FAIL result fn=%h x=%h y=%h got err=%b res=%h z=%b n=%b want err=%b res=%h z=%b n=%b",
                             h.fn, h.x, h.y, ERR, RESULT, ZERO, NEG, h.err, h.res, h.zero, h.neg);
                end else begin
                    $display("op fn=%h x=%h y=%h err=%b res=%h z=%b n=%b done@%0d",
                             h.fn, h.x, h.y, ERR, RESULT, ZERO, NEG, cyc);
                end
                void'(q.pop_front());
            end else if (d > 3) begin
                failures++;
                $display("FAIL timeout fn=%h got no DONE by age %0d want age 3", h.fn, d);
                void'(q.pop_front());
            end
        end
    end

    task automatic drive_cycle(input logic s, input logic [3:0] f, input logic [N-1:0] x,
                               input logic [N-1:0] y, output logic acc);
        @(posedge CLKb); #1;
        START = s; FN_IN = f; X = x; Y = y;
        acc = 1'b0;
        if (s && READY && RSTb) begin
            push(f, x, y, cyc + 1);
            acc = 1'b1;
        end
    endtask

    task automatic do_op(input logic [3:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive_cycle(1'b1, f, x, y, acc);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept fn=%h got READY never high want accept within 20 cycles", f);
        end
        drive_cycle(1'b0, 4'($urandom), N'($urandom), N'($urandom), acc);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic acc;
        repeat (2) @(posedge CLKb);
        #1 check("reset_ready", {31'd0, READY}, 32'd1);
        check("reset_result", {20'd0, RESULT, ZERO, NEG}, 32'd0);
        check("reset_strobes", {28'd0, DONE, AIN, GIN, GOUT}, 32'd0);
        RSTb = 1'b1;

        do_op(4'b0010, 10'd5, 10'd3);
        do_op(4'b0011, 10'd3, 10'd5);
        do_op(4'b0110, 10'h0F0, 10'h00F);
        do_op(4'b0000, 10'd7, 10'd7);
        do_op(4'b1011, 10'h200, 10'd2);
        do_op(4'b1001, 10'd1, 10'd9);

        // START held high with operands changing every cycle.
        for (int i = 0; i < 40; i++)
            drive_cycle(1'b1, 4'($urandom_range(0, 12)), N'($urandom), N'($urandom), acc);
        drive_cycle(1'b0, 4'd0, '0, '0, acc);

        // Reset in the middle of EXEC.
        do_op(4'b0010, 10'd100, 10'd23);
        @(posedge CLKb); #1;
        check("exec_gin", {31'd0, GIN}, 32'd1);
        RSTb = 1'b0;
        #1;
        check("rst_drop", {28'd0, GIN, DONE, AIN, GOUT}, 32'd0);
        check("rst_regs", {18'd0, RESULT, FN}, 32'd0);
        q.delete();
        last_res = '0; last_zero = 1'b0; last_neg = 1'b0;
        repeat (2) @(posedge CLKb);
        #1 RSTb = 1'b1;
        #1 check("post_rst_ready", {31'd0, READY}, 32'd1);
        do_op(4'b0010, 10'd1, 10'd1);

        for (int i = 0; i < 150; i++)
            drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        N'($urandom), N'($urandom), acc);
        drive_cycle(1'b0, 4'd0, '0, '0, acc);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge CLKb);
        #1 check("drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
